bcd_timekeeper: RTL
===================

# bcd_timekeeper

Parametrised 24-hour BCD time-of-day counter with an integrated tick prescaler, validated synchronous time load, 12/24-hour display mode and a single alarm comparator. It supersedes the fixed 1 Hz divider plus decimal counter pair. It sits between the board clock and the display/button logic, and it uses the same 20-bit packed time format the display path already consumes.

## Interface
Time format, 20 bits: hh_hhhh:mmm_mmmm:sss_ssss, i.e. {hrs_tens[1:0], hrs_unit[3:0], min_tens[2:0], min_unit[3:0], sec_tens[2:0], sec_unit[3:0]}.

Parameters
- TICK_DIV, default 50_000_000: clk cycles per second tick. Must be ≥ 2.
- CNT_W, default $clog2(TICK_DIV): prescaler counter width.

Ports
- clk, input, 1: system clock. Single clock domain.
- rst_n, input, 1: reset, synchronous, active-low.
- run, input, 1: 1 lets the prescaler advance; 0 freezes time and the prescaler.
- mode_12h, input, 1: 1 selects 12-hour presentation on time_out.
- load_valid, input, 1: one-cycle request to overwrite the time.
- load_time, input, 20: time for a load, packed format.
- alarm_wr, input, 1: writes alarm_in to the alarm register.
- alarm_in, input, 13: alarm hh:mm, {hrs_tens, hrs_unit, min_tens, min_unit}.
- alarm_en, input, 1: alarm compare enable.
- time_out, output, 20: current time in packed format, per mode_12h.
- pm, output, 1: 1 when the internal hour is 12–23. Valid in both modes.
- tick, output, 1: one-cycle pulse on each second increment.
- day_wrap, output, 1: one-cycle pulse on the 23:59:59→00:00:00 step.
- alarm_hit, output, 1: one-cycle pulse on an alarm match.
- load_err, output, 1: one-cycle pulse when a load is rejected.

## Operation
- Internal state is always 24-hour BCD: sec, min, hour, the prescaler, and the alarm register.
- Reset (rst_n=0 at a clk edge) sets:
  - time = 00:00:00, prescaler = 0, alarm = 00:00;
  - all pulse outputs = 0, pm = 0.
  - time_out then shows 00:00:00 in 24h mode and 12:00:00 in 12h mode.
- Prescaler:
  - When run=1, it increments each cycle.
  - At TICK_DIV-1 it wraps to 0 and asserts the internal tick.
- Ripple carry:
  - sec_unit 9→0 carries to sec_tens.
  - sec_tens 5→0 carries to minutes; minutes follow the same rule.
  - Hours: 23→00 asserts day_wrap; 09→10 and 19→20 roll the tens digit.
- Load:
  - Accepted only if every digit is in range: sec and min units ≤9, tens ≤5, hours ≤23.
  - Accepted: time ← load_time and prescaler ← 0. The next tick comes a full TICK_DIV cycles later.
  - Rejected: state unchanged and load_err pulses.
- Priority within one cycle: reset > load > tick. A load in a tick cycle discards that tick (no tick, day_wrap or alarm_hit pulse).
- alarm_wr stores alarm_in unvalidated. An out-of-range alarm never matches.
- alarm_hit pulses when alarm_en=1 and a tick makes the time equal alarm hh:mm:00. A load landing on the alarm time does not fire.
- 12h presentation, combinational from state:
  - hour 00 → 12;
  - hours 13–23 → 01–11;
  - hours 01–12 unchanged.
  - Minutes and seconds are unchanged. pm is independent of mode.

## Timing
- The tick, day_wrap and alarm_hit pulses are registered and assert in the same cycle the new time is visible on time_out, one clk after the prescaler terminal-count edge.
- load_err asserts one cycle after the load_valid sample.
- After an accepted load, time_out shows load_time one cycle after load_valid.
- mode_12h changes affect time_out in the same cycle (combinational path, no latency).
- run=0 holds the prescaler value. Resuming continues the count; the partial second is preserved.
- Reset asserted mid-second discards the prescaler count. Any pending pulses are 0 in the following cycle.
- Alarm written in the same cycle as a matching tick: the comparison uses the old alarm value.

## Structure
- Package clock_pkg holds:
  - time field widths and bit offsets (SEC_U_LSB etc.);
  - typedef time_t (20-bit packed struct) and alarm_t (13-bit);
  - constants MAX_SEC_TENS=5, MAX_HRS=23;
  - function time_valid(time_t) for load checking;
  - function to_12h(time_t).
- Sub-module tick_prescaler(TICK_DIV) has inputs clk, rst_n, run and clear, and output tick. The rest of the logic stays in bcd_timekeeper.

## Test plan
- Reset, TICK_DIV=4, run=1 → time_out=00:00:00. tick every 4 cycles. After 60 ticks, time_out=00:01:00.
- Load 23:59:58, then 2 ticks → 23:59:59, then 00:00:00 with day_wrap=1 for exactly one cycle.
- load_time=12:60:00 → load_err=1 one cycle later, time unchanged. Load 24:00:00 → also rejected.
- Alarm 07:30 with alarm_en=1, load 07:29:59, one tick → alarm_hit pulse. Loading 07:30:00 directly → no pulse.
- mode_12h=1: internal 00:15:00 → 12:15:00 with pm=0. 13:05:07 → 01:05:07 with pm=1. 12:00:00 → 12:00:00 with pm=1.
- run=0 for 10 cycles mid-second → no tick, time held. Resume → next tick after the remaining count. rst_n=0 during a load cycle → 00:00:00, no load_err.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: packed time format, field limits and helpers shared by the timekeeper.
package clock_pkg;
  localparam int TIME_W     = 20;
  localparam int ALARM_W    = 13;
  localparam int SEC_U_W    = 4;
  localparam int SEC_T_W    = 3;
  localparam int MIN_U_W    = 4;
  localparam int MIN_T_W    = 3;
  localparam int HRS_U_W    = 4;
  localparam int HRS_T_W    = 2;
  localparam int SEC_U_LSB  = 0;
  localparam int SEC_T_LSB  = 4;
  localparam int MIN_U_LSB  = 7;
  localparam int MIN_T_LSB  = 11;
  localparam int HRS_U_LSB  = 14;
  localparam int HRS_T_LSB  = 18;
  localparam int MAX_SEC_TENS = 5;
  localparam int MAX_HRS      = 23;

  typedef struct packed {
    logic [HRS_T_W-1:0] hrs_t;
    logic [HRS_U_W-1:0] hrs_u;
    logic [MIN_T_W-1:0] min_t;
    logic [MIN_U_W-1:0] min_u;
    logic [SEC_T_W-1:0] sec_t;
    logic [SEC_U_W-1:0] sec_u;
  } time_t;

  typedef struct packed {
    logic [HRS_T_W-1:0] hrs_t;
    logic [HRS_U_W-1:0] hrs_u;
    logic [MIN_T_W-1:0] min_t;
    logic [MIN_U_W-1:0] min_u;
  } alarm_t;

  function automatic int hour_of(input time_t t);
    return int'(t.hrs_t) * 10 + int'(t.hrs_u);
  endfunction

  function automatic logic time_valid(input time_t t);
    return t.sec_u <= 4'd9 && t.sec_t <= 3'(MAX_SEC_TENS) &&
           t.min_u <= 4'd9 && t.min_t <= 3'(MAX_SEC_TENS) &&
           t.hrs_u <= 4'd9 && hour_of(t) <= MAX_HRS;
  endfunction

  function automatic logic is_pm(input time_t t);
    return hour_of(t) >= 12;
  endfunction

  // BCD remap of the hour digits only; 00 shows as 12, 13-23 as 01-11
  function automatic time_t to_12h(input time_t t);
    time_t r;
    r = t;
    if (t.hrs_t == 2'd0 && t.hrs_u == 4'd0) {r.hrs_t, r.hrs_u} = {2'd1, 4'd2};
    else if (t.hrs_t == 2'd1 && t.hrs_u >= 4'd3) {r.hrs_t, r.hrs_u} = {2'd0, t.hrs_u - 4'd2};
    else if (t.hrs_t == 2'd2 && t.hrs_u <= 4'd1) {r.hrs_t, r.hrs_u} = {2'd0, t.hrs_u + 4'd8};
    else if (t.hrs_t == 2'd2) {r.hrs_t, r.hrs_u} = {2'd1, t.hrs_u - 4'd2};
    return r;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle terminal-count strobe every TICK_DIV running cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);
  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = r_cnt == CNT_W'(TICK_DIV - 1);
  assign tick = run && w_tc;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) r_cnt <= '0;
    else if (run) r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: 24-hour BCD time-of-day counter with validated load, alarm and 12h view.
module bcd_timekeeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               mode_12h,
  input  logic               load_valid,
  input  logic [TIME_W-1:0]  load_time,
  input  logic               alarm_wr,
  input  logic [ALARM_W-1:0] alarm_in,
  input  logic               alarm_en,
  output logic [TIME_W-1:0]  time_out,
  output logic               pm,
  output logic               tick,
  output logic               day_wrap,
  output logic               alarm_hit,
  output logic               load_err
);
  time_t  r_time;
  alarm_t r_alarm;
  logic   r_tick, r_wrap, r_hit, r_err;
  time_t  w_inc;
  logic   w_tc, w_load_ok, w_adv, w_day, w_match;
  logic   w_c0, w_c1, w_c2, w_c3;

  tick_prescaler #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clear(w_load_ok),
    .tick (w_tc)
  );

  assign w_load_ok = load_valid && time_valid(time_t'(load_time));
  assign w_adv     = w_tc && !w_load_ok;

  // Ripple carries: each stage rolls only when every lower digit is at its maximum
  assign w_c0  = r_time.sec_u == 4'd9;
  assign w_c1  = w_c0 && r_time.sec_t == 3'(MAX_SEC_TENS);
  assign w_c2  = w_c1 && r_time.min_u == 4'd9;
  assign w_c3  = w_c2 && r_time.min_t == 3'(MAX_SEC_TENS);
  assign w_day = w_c3 && hour_of(r_time) == MAX_HRS;

  always_comb begin
    w_inc       = r_time;
    w_inc.sec_u = w_c0 ? 4'd0 : r_time.sec_u + 4'd1;
    w_inc.sec_t = w_c1 ? 3'd0 : w_c0 ? r_time.sec_t + 3'd1 : r_time.sec_t;
    w_inc.min_u = w_c2 ? 4'd0 : w_c1 ? r_time.min_u + 4'd1 : r_time.min_u;
    w_inc.min_t = w_c3 ? 3'd0 : w_c2 ? r_time.min_t + 3'd1 : r_time.min_t;
    w_inc.hrs_u = !w_c3 ? r_time.hrs_u : (w_day || r_time.hrs_u == 4'd9) ? 4'd0 : r_time.hrs_u + 4'd1;
    w_inc.hrs_t = !w_c3 ? r_time.hrs_t : w_day ? 2'd0 : r_time.hrs_u == 4'd9 ? r_time.hrs_t + 2'd1 : r_time.hrs_t;
  end

  // Incremented time is always in range, so an out-of-range alarm can never compare equal
  assign w_match = alarm_en && {w_inc.hrs_t, w_inc.hrs_u, w_inc.min_t, w_inc.min_u} == r_alarm &&
                   w_inc.sec_t == 3'd0 && w_inc.sec_u == 4'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_time  <= '0;
      r_alarm <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_time  <= w_load_ok ? time_t'(load_time) : w_adv ? w_inc : r_time;
      r_tick  <= w_adv;
      r_wrap  <= w_adv && w_day;
      r_hit   <= w_adv && w_match;
      r_err   <= load_valid && !w_load_ok;
      if (alarm_wr) r_alarm <= alarm_t'(alarm_in);
    end
  end

  assign time_out  = mode_12h ? to_12h(r_time) : r_time;
  assign pm        = is_pm(r_time);
  assign tick      = r_tick;
  assign day_wrap  = r_wrap;
  assign alarm_hit = r_hit;
  assign load_err  = r_err;
endmodule
